// File: rtl/hiscore_pkg.sv
// rtl/hiscore_pkg.sv - shared types for the hiscore RAM port arbiter
package hiscore_pkg;

  typedef logic [2:0] hs_arb_state_t;

  localparam hs_arb_state_t ST_IDLE        = 3'd0;
  localparam hs_arb_state_t ST_PAUSE_WAIT  = 3'd1;
  localparam hs_arb_state_t ST_SETTLE_WAIT = 3'd2;
  localparam hs_arb_state_t ST_GRANT_DL    = 3'd3;
  localparam hs_arb_state_t ST_GRANT_UL    = 3'd4;
  localparam hs_arb_state_t ST_SCAN        = 3'd5;
  localparam hs_arb_state_t ST_COMPARE     = 3'd6;
  localparam hs_arb_state_t ST_RELEASE     = 3'd7;

  typedef enum logic [1:0] {OWN_DL, OWN_UL, OWN_AS, OWN_STORE} owner_t;

  typedef logic [15:0] ck_t;
  localparam ck_t CK_INIT = 16'h0000;

endpackage

// File: rtl/hiscore_checksum.sv
// rtl/hiscore_checksum.sv - {8-bit wrapping sum, 8-bit XOR} accumulator over RAM bytes
module hiscore_checksum
  import hiscore_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic [15:0] ck
);

  ck_t acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= CK_INIT;
    end else if (clear) begin
      acc <= CK_INIT;
    end else if (valid) begin
      acc <= {acc[15:8] + data, acc[7:0] ^ data};
    end
  end

  assign ck = acc;

endmodule

// File: rtl/hiscore_port_arbiter.sv
// rtl/hiscore_port_arbiter.sv - shares the hiscore RAM port between NVRAM download, upload and autosave
module hiscore_port_arbiter
  import hiscore_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int SETTLE = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_req,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  input  logic              ul_req,
  input  logic [ADDR_W-1:0] ul_addr,
  output logic [DATA_W-1:0] ul_data,
  input  logic              as_en,
  input  logic              as_tick,
  output logic              upload_req,
  output logic              pause_req,
  input  logic              paused,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int N  = 1 << ADDR_W;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [ADDR_W:0] SCAN_LAST   = N[ADDR_W:0];

  hs_arb_state_t   state;
  owner_t          owner;
  logic [SW-1:0]   settle_cnt;
  logic [ADDR_W:0] scan_cnt;
  logic            ack_armed;
  logic            store_pending;
  logic            saved_valid;
  ck_t             saved_ck;
  logic [15:0]     ck;
  logic            as_fire;
  logic            owner_dropped;

  assign as_fire       = as_en & as_tick & saved_valid;
  assign owner_dropped = (owner == OWN_DL && !dl_req) || (owner == OWN_UL && !ul_req);

  // ack_armed: an acknowledge only counts once paused has been seen low in this wait
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      owner         <= OWN_DL;
      settle_cnt    <= '0;
      scan_cnt      <= '0;
      ack_armed     <= 1'b0;
      store_pending <= 1'b0;
      saved_valid   <= 1'b0;
      saved_ck      <= CK_INIT;
    end else begin
      case (state)
        ST_IDLE: begin
          ack_armed  <= 1'b0;
          settle_cnt <= '0;
          scan_cnt   <= '0;
          if (dl_req) begin
            owner <= OWN_DL;
            state <= ST_PAUSE_WAIT;
          end else if (ul_req) begin
            owner <= OWN_UL;
            state <= ST_PAUSE_WAIT;
          end else if (as_fire) begin
            owner <= OWN_AS;
            state <= ST_PAUSE_WAIT;
          end else if (store_pending) begin
            owner <= OWN_STORE;
            state <= ST_PAUSE_WAIT;
          end
        end
        ST_PAUSE_WAIT: begin
          if (!paused) ack_armed <= 1'b1;
          if (owner_dropped)           state <= ST_RELEASE;
          else if (paused && ack_armed) state <= ST_SETTLE_WAIT;
        end
        ST_SETTLE_WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            case (owner)
              OWN_DL:  state <= ST_GRANT_DL;
              OWN_UL:  state <= ST_GRANT_UL;
              default: state <= ST_SCAN;
            endcase
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_GRANT_DL: begin
          if (!dl_req) begin
            store_pending <= 1'b1;
            state         <= ST_RELEASE;
          end
        end
        ST_GRANT_UL: begin
          if (!ul_req) begin
            store_pending <= 1'b1;
            state         <= ST_RELEASE;
          end
        end
        ST_SCAN: begin
          if (scan_cnt == SCAN_LAST) state <= ST_COMPARE;
          else                       scan_cnt <= scan_cnt + 1'b1;
        end
        ST_COMPARE: begin
          if (owner == OWN_STORE) begin
            saved_ck      <= ck;
            saved_valid   <= 1'b1;
            store_pending <= 1'b0;
          end
          state <= ST_RELEASE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM read data lags the address by one cycle, so byte k arrives while scan_cnt is k+1
  hiscore_checksum u_checksum (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .clear (state != ST_SCAN),
    .valid (state == ST_SCAN && scan_cnt != '0),
    .data  (ram_rdata[7:0]),
    .ck    (ck)
  );

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ul_data   = '0;
    case (state)
      ST_GRANT_DL: begin
        ram_addr  = dl_addr;
        ram_wdata = dl_data;
        ram_we    = dl_wr;
      end
      ST_GRANT_UL: begin
        ram_addr = ul_addr;
        ul_data  = ram_rdata;
      end
      ST_SCAN: ram_addr = scan_cnt[ADDR_W-1:0];
      default: ;
    endcase
  end

  assign pause_req  = (state != ST_IDLE) && (state != ST_RELEASE);
  assign upload_req = (state == ST_COMPARE) && (owner != OWN_STORE) && (ck != saved_ck);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_hiscore_port_arbiter.sv
// tb/tb_hiscore_port_arbiter.sv - directed scoreboard bench for hiscore_port_arbiter
module tb_hiscore_port_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int N      = 64;

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b0;
  logic              dl_req   = 1'b0;
  logic              dl_wr    = 1'b0;
  logic [ADDR_W-1:0] dl_addr  = '0;
  logic [DATA_W-1:0] dl_data  = '0;
  logic              ul_req   = 1'b0;
  logic [ADDR_W-1:0] ul_addr  = '0;
  logic              as_en    = 1'b0;
  logic              as_tick  = 1'b0;
  logic              paused   = 1'b0;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [DATA_W-1:0] ul_data;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              upload_req, pause_req, ram_we, busy;

  logic [7:0]        mem [N];
  logic              poke_en   = 1'b0;
  logic [ADDR_W-1:0] poke_addr = '0;
  logic [7:0]        poke_data = '0;
  bit                pause_auto = 1'b1;
  int                pcnt = 0;

  int vectors = 0;
  int errs    = 0;
  int exp_q[$];

  int cyc = 0, up_total = 0, up_base = 0, up_cyc = 0, top_cyc = 0;
  int busy_total = 0, sweep_total = 0, order_err = 0;
  int paused_rise_cyc = 0, first_we_cyc = 0;
  bit paused_seen = 1'b0, we_seen = 1'b0;
  bit prev_busy = 1'b0, prev_up = 1'b0, prev_paused = 1'b0, prev_sweep = 1'b0;
  bit pr_after_up = 1'b1;
  logic [ADDR_W-1:0] prev_addr = '0;

  hiscore_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE(2)) dut (
    .clk_sys    (clk),
    .reset_n    (reset_n),
    .dl_req     (dl_req),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .ul_req     (ul_req),
    .ul_addr    (ul_addr),
    .ul_data    (ul_data),
    .as_en      (as_en),
    .as_tick    (as_tick),
    .upload_req (upload_req),
    .pause_req  (pause_req),
    .paused     (paused),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Hiscore RAM with registered read and a bench-side poke port
  always @(posedge clk) begin
    if (poke_en)     mem[poke_addr] <= poke_data;
    else if (ram_we) mem[ram_addr]  <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // CPU pause block: acknowledges 3 cycles after the request, drops as soon as it goes away
  always @(posedge clk) begin
    if (!pause_req) begin
      paused <= 1'b0;
      pcnt   <= 0;
    end else if (pause_auto) begin
      if (pcnt == 2) paused <= 1'b1;
      else           pcnt   <= pcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc         <= cyc + 1;
    prev_busy   <= busy;
    prev_up     <= upload_req;
    prev_paused <= paused;
    prev_addr   <= ram_addr;
    prev_sweep  <= pause_req && paused && !ram_we && ram_addr != '0;
    if (busy) busy_total <= busy_total + 1;
    if (upload_req) begin
      up_total <= up_total + 1;
      up_cyc   <= cyc;
    end
    if (prev_up) pr_after_up <= pause_req;
    if (paused && !prev_paused && !paused_seen) begin
      paused_seen     <= 1'b1;
      paused_rise_cyc <= cyc;
    end
    if (ram_we && !we_seen) begin
      we_seen      <= 1'b1;
      first_we_cyc <= cyc;
    end
    if (pause_req && paused && !ram_we && ram_addr != '0) begin
      sweep_total <= sweep_total + 1;
      if (prev_sweep && 32'(ram_addr) != 32'(prev_addr) + 1) order_err <= order_err + 1;
    end
    if (ram_addr == 6'd63 && pause_req && !ram_we) top_cyc <= cyc;
    if (prev_busy && !busy) begin
      if (exp_q.size() == 0) chk("unexpected_op", 1, 0);
      else                   chk("op_upload_pulses", up_total - up_base, exp_q.pop_front());
      up_base <= up_total;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_paused(input int budget);
    int n = 0;
    while (!paused && n < budget) begin
      step(1);
      n++;
    end
    chk("paused_timeout", paused, 1);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    int q = 0;
    while (q < 3 && n < budget) begin
      step(1);
      n++;
      q = busy ? 0 : q + 1;
    end
    chk("quiet_timeout", q >= 3, 1);
  endtask

  task automatic tick();
    as_tick = 1'b1;
    step(1);
    as_tick = 1'b0;
  endtask

  function automatic logic [15:0] model_ck();
    logic [7:0] s = 8'h00;
    logic [7:0] x = 8'h00;
    for (int i = 0; i < N; i++) begin
      s = s + mem[i];
      x = x ^ mem[i];
    end
    return {s, x};
  endfunction

  initial begin
    int bad;
    int snap_sweep, snap_order, snap_busy, n;

    step(3);
    chk("rst_pause_req_in_reset", pause_req, 0);
    chk("rst_busy_in_reset", busy, 0);
    reset_n = 1'b1;
    step(2);
    chk("rst_pause_req", pause_req, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_upload_req", upload_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ul_data", ul_data, 0);
    chk("rst_saved_valid", dut.saved_valid, 0);
    as_en = 1'b1;

    // Download 0x00..0x3F, then the store scan
    exp_q.push_back(0);
    exp_q.push_back(0);
    dl_req = 1'b1;
    dl_wr  = 1'b1;
    wait_paused(50);
    step(5);
    for (int i = 0; i < N; i++) begin
      dl_addr = ADDR_W'(i);
      dl_data = DATA_W'(i);
      step(1);
    end
    dl_wr   = 1'b0;
    dl_addr = '0;
    dl_data = '0;
    dl_req  = 1'b0;
    wait_quiet(500);
    chk("grant_lag_ge_2", (first_we_cyc - paused_rise_cyc) >= 2, 1);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== 8'(i)) bad++;
    chk("dl_pattern_bad_bytes", bad, 0);
    chk("store_saved_ck", dut.saved_ck, 16'hE000);
    chk("store_saved_valid", dut.saved_valid, 1);

    // Autosave with RAM unchanged
    exp_q.push_back(0);
    tick();
    wait_quiet(500);

    // Autosave after poking addr 5
    poke_addr = 6'd5;
    poke_data = 8'hFF;
    poke_en   = 1'b1;
    step(1);
    poke_en   = 1'b0;
    exp_q.push_back(1);
    snap_sweep = sweep_total;
    snap_order = order_err;
    tick();
    wait_quiet(500);
    chk("scan_sweep_cycles", sweep_total - snap_sweep, N - 1);
    chk("scan_addr_order_errs", order_err - snap_order, 0);
    chk("upload_after_last_addr", up_cyc - top_cyc, 2);
    chk("pause_req_after_upload", pr_after_up, 0);

    // Download and as_tick in the same IDLE cycle
    exp_q.push_back(0);
    exp_q.push_back(0);
    dl_req  = 1'b1;
    as_tick = 1'b1;
    step(1);
    as_tick = 1'b0;
    wait_paused(50);
    step(6);
    dl_req = 1'b0;
    wait_quiet(500);
    chk("contention_saved_ck", dut.saved_ck, model_ck());

    // Upload request withdrawn before the acknowledge
    pause_auto = 1'b0;
    exp_q.push_back(0);
    ul_req = 1'b1;
    step(2);
    ul_req = 1'b0;
    step(1);
    chk("abort_pause_req", pause_req, 0);
    step(1);
    chk("abort_busy", busy, 0);
    snap_busy = busy_total;
    step(10);
    chk("abort_no_store", busy_total - snap_busy, 0);
    pause_auto = 1'b1;

    // Reset in the middle of an autosave scan
    exp_q.push_back(0);
    tick();
    n = 0;
    while (!(ram_addr == 6'd30 && pause_req && paused && !ram_we) && n < 300) begin
      step(1);
      n++;
    end
    chk("scan_byte30_timeout", n < 300, 1);
    reset_n = 1'b0;
    #1;
    chk("midscan_rst_pause_req", pause_req, 0);
    chk("midscan_rst_ram_addr", ram_addr, 0);
    chk("midscan_rst_busy", busy, 0);
    step(3);
    reset_n = 1'b1;
    step(1);
    chk("midscan_saved_valid", dut.saved_valid, 0);
    snap_busy = busy_total;
    tick();
    step(10);
    chk("no_autosave_unsaved", busy_total - snap_busy, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
